// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and helpers for the UART transmit feeder (state encoding, guard length, FIFO depth).
package uart_tx_feeder_pkg;

  typedef enum logic [1:0] {
    GUARD = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DEPTH = 16;

  // One full frame (start + data + stop) worth of clocks.
  function automatic int unsigned guard_len(input int unsigned clks_per_bit,
                                            input int unsigned bits);
    return clks_per_bit * (bits + 2);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with separate occupancy count and registered empty/full flags.
module uart_sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (!push && pop) begin
      level_next = level - LW'(1);
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == LW'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers writer bytes and launches them one frame at a time into the UART transmitter.
// Optional sticky overflow flag o_ovf is enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned BITS         = 8,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic [BITS-1:0] i_dat,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_tx_active,
  output logic [BITS-1:0] o_tx_dat,
  input  logic            i_tx_done,
  output logic [AW:0]     o_level,
  output logic            o_empty,
  output logic            o_full
`ifdef UART_TX_FEEDER_OVF_EN
  ,
  output logic            o_ovf
`endif
);

  localparam int unsigned GUARD_LEN = guard_len(CLKS_PER_BIT, BITS);
  localparam int unsigned GW        = $clog2(GUARD_LEN + 1);

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   guard_q;
  logic [GW-1:0]   guard_d;
  logic            tx_active_d;
  logic [BITS-1:0] tx_dat_d;
  logic [BITS-1:0] head;
  logic            push;
  logic            pop;

  assign o_ready = !o_full;
  assign push    = i_valid && o_ready;

  uart_sync_fifo #(
    .WIDTH (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_wb_clk),
    .rst       (i_wb_rst),
    .push      (push),
    .push_data (i_dat),
    .pop       (pop),
    .head      (head),
    .level     (o_level),
    .empty     (o_empty),
    .full      (o_full)
  );

  // The transmitter has no reset, so GUARD waits out a possible in-flight frame.
  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    pop         = 1'b0;
    tx_active_d = 1'b0;
    tx_dat_d    = o_tx_dat;
    case (state_q)
      GUARD: begin
        if (i_tx_done || (guard_q <= GW'(1))) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      IDLE: begin
        if (!o_empty) begin
          pop         = 1'b1;
          tx_active_d = 1'b1;
          tx_dat_d    = head;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (i_tx_done) begin
          if (!o_empty) begin
            pop         = 1'b1;
            tx_active_d = 1'b1;
            tx_dat_d    = head;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = GUARD;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q     <= GUARD;
      guard_q     <= GW'(GUARD_LEN);
      o_tx_active <= 1'b0;
      o_tx_dat    <= '1;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      o_tx_active <= tx_active_d;
      o_tx_dat    <= tx_dat_d;
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  // Sticky record of any write attempt made while the FIFO was full.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_ovf <= 1'b0;
    end else if (i_valid && o_full) begin
      o_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: accepted bytes are queued, launches are popped and compared.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       i_wb_rst;
  logic [7:0] i_dat;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx_active;
  logic [7:0] o_tx_dat;
  logic       i_tx_done;
  logic [4:0] o_level;
  logic       o_empty;
  logic       o_full;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       o_ovf;
`endif

  always #5 clk = ~clk;

  uart_tx_feeder dut (
    .i_wb_clk    (clk),
    .i_wb_rst    (i_wb_rst),
    .i_dat       (i_dat),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_tx_active (o_tx_active),
    .o_tx_dat    (o_tx_dat),
    .i_tx_done   (i_tx_done),
    .o_level     (o_level),
    .o_empty     (o_empty),
    .o_full      (o_full)
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    .o_ovf       (o_ovf)
`endif
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         man_req = 0;
  int         man_ack = 0;
  int         quiet;
  int         n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push1(input logic [7:0] d);
    i_valid = 1'b1;
    i_dat   = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic done_pulse();
    man_req++;
  endtask

  // Expected bytes enter the scoreboard at the accepting edge.
  always @(posedge clk) begin
    if (!i_wb_rst && i_valid && o_ready) exp_q.push_back(i_dat);
  end

  // Transmitter stub: turns each requested done into a one-cycle pulse.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (man_req != man_ack) begin
        man_ack++;
        i_tx_done = 1'b1;
      end else begin
        i_tx_done = 1'b0;
      end
    end
  end

  // Launch monitor: data order, single-cycle strobe, data held between strobes.
  initial begin
    logic       prev_active;
    logic [7:0] last_dat;
    prev_active = 1'b0;
    last_dat    = 8'hFF;
    forever begin
      @(negedge clk);
      #2;
      if (i_wb_rst) begin
        prev_active = 1'b0;
        last_dat    = 8'hFF;
        continue;
      end
      if (o_tx_active) begin
        check("single_cycle_strobe", 32'(prev_active), 0);
        if (exp_q.size() == 0) check("launch_without_pending_byte", 32'(o_tx_active), 0);
        else check("launch_data", 32'(o_tx_dat), 32'(exp_q.pop_front()));
        last_dat = o_tx_dat;
      end else if (o_tx_dat !== last_dat) begin
        check("tx_dat_stable", 32'(o_tx_dat), 32'(last_dat));
      end
      prev_active = o_tx_active;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_wb_rst = 1'b1;
    i_valid  = 1'b0;
    i_dat    = 8'h00;

    // Reset values, then full-length guard with one byte waiting.
    repeat (3) tick();
    check("rst_active", 32'(o_tx_active), 0);
    check("rst_dat", 32'(o_tx_dat), 32'hFF);
    check("rst_level", 32'(o_level), 0);
    check("rst_empty", 32'(o_empty), 1);
    check("rst_full", 32'(o_full), 0);
    check("rst_ready", 32'(o_ready), 1);
    i_wb_rst = 1'b0;
    push1(8'hA5);
    check("guard_level_after_push", 32'(o_level), 1);
    quiet = 0;
    for (int m = 2; m <= 1040; m++) begin
      tick();
      if (o_tx_active) quiet++;
    end
    check("guard_no_launch", 32'(quiet), 0);
    tick();
    check("guard_end_launch", 32'(o_tx_active), 1);
    check("guard_end_level", 32'(o_level), 0);
    tick();
    check("launch_one_cycle", 32'(o_tx_active), 0);

    // Early guard exit on done, then 2-cycle launch latency.
    i_wb_rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    i_wb_rst = 1'b0;
    repeat (50) tick();
    done_pulse();
    quiet = 0;
    for (int m = 0; m < 10; m++) begin
      tick();
      if (o_tx_active) quiet++;
    end
    check("early_exit_quiet", 32'(quiet), 0);
    push1(8'h3C);
    check("latency_level", 32'(o_level), 1);
    check("latency_not_yet", 32'(o_tx_active), 0);
    tick();
    check("latency_launch", 32'(o_tx_active), 1);

    // Fill the FIFO while BUSY; a further write stalls.
    for (int i = 1; i <= 16; i++) push1(8'(i));
    i_valid = 1'b1;
    i_dat   = 8'h11;
    check("fill_full", 32'(o_full), 1);
    check("fill_ready", 32'(o_ready), 0);
    check("fill_level", 32'(o_level), 16);
    repeat (2) tick();
    i_valid = 1'b0;
    check("stall_level", 32'(o_level), 16);

    // Back-to-back launches, one per done.
    for (int i = 0; i < 16; i++) begin
      done_pulse();
      tick();
      check("b2b_launch", 32'(o_tx_active), 1);
      check("b2b_level", 32'(o_level), 32'(15 - i));
      repeat (2) tick();
    end
    done_pulse();
    tick();
    check("drain_no_launch", 32'(o_tx_active), 0);
    check("drain_empty", 32'(o_empty), 1);
    tick();

    // Push coincident with done: level unchanged, order kept, pointers wrapped.
    push1(8'h77);
    tick();
    check("idle_launch_77", 32'(o_tx_active), 1);
    push1(8'h66);
    check("one_queued", 32'(o_level), 1);
    i_valid = 1'b1;
    i_dat   = 8'h55;
    done_pulse();
    tick();
    i_valid = 1'b0;
    check("simul_level", 32'(o_level), 1);
    check("simul_launch", 32'(o_tx_active), 1);
    tick();
    done_pulse();
    tick();
    check("simul_second_launch", 32'(o_tx_active), 1);
    check("simul_second_level", 32'(o_level), 0);
    done_pulse();
    tick();
    tick();

    // Reset while BUSY with bytes queued.
    push1(8'h90);
    tick();
    check("pre_rst_launch", 32'(o_tx_active), 1);
    for (int i = 1; i <= 5; i++) push1(8'(8'h90 + i));
    check("pre_rst_level", 32'(o_level), 5);
    i_wb_rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_level", 32'(o_level), 0);
    check("mid_rst_empty", 32'(o_empty), 1);
    check("mid_rst_active", 32'(o_tx_active), 0);
    check("mid_rst_dat", 32'(o_tx_dat), 32'hFF);
    i_wb_rst = 1'b0;
    push1(8'hC1);
    check("rst_guard_level", 32'(o_level), 1);
    quiet = 0;
    for (int m = 0; m < 100; m++) begin
      tick();
      if (o_tx_active) quiet++;
    end
    check("rst_guard_quiet", 32'(quiet), 0);
    done_pulse();
    tick();
    check("rst_guard_exit_no_launch", 32'(o_tx_active), 0);
    tick();
    check("rst_guard_exit_launch", 32'(o_tx_active), 1);
    done_pulse();
    repeat (2) tick();

`ifdef UART_TX_FEEDER_OVF_EN
    // Sticky overflow on a write attempt while full.
    check("ovf_clear", 32'(o_ovf), 0);
    push1(8'hD0);
    tick();
    for (int i = 0; i < 16; i++) push1(8'(8'hE0 + i));
    check("ovf_full", 32'(o_full), 1);
    check("ovf_not_yet", 32'(o_ovf), 0);
    i_valid = 1'b1;
    i_dat   = 8'hFE;
    tick();
    i_valid = 1'b0;
    check("ovf_set", 32'(o_ovf), 1);
    for (int i = 0; i < 17; i++) begin
      done_pulse();
      repeat (2) tick();
    end
    check("ovf_drained", 32'(o_empty), 1);
    check("ovf_sticky", 32'(o_ovf), 1);
    i_wb_rst = 1'b1;
    exp_q.delete();
    tick();
    check("ovf_rst", 32'(o_ovf), 0);
    i_wb_rst = 1'b0;
    tick();
`endif

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
